// File: rtl/fft_pkg.sv
// Shared widths, complex sample types and the 18-bit saturator for the FFT datapath.
package fft_pkg;

    localparam int DW        = 18;
    localparam int PW        = 36;
    localparam int WW        = PW + 4;
    localparam int RND_SHIFT = 17;

    typedef logic signed [DW-1:0] sample_t;
    typedef logic signed [WW-1:0] wide_t;

    typedef struct packed {
        sample_t re;
        sample_t im;
    } cplx_t;

    typedef struct packed {
        logic    ovf;
        sample_t v;
    } sat_t;

    // Half an LSB of the Q1.17 result, expressed in Q2.34 product units.
    localparam wide_t RND_HALF = wide_t'(1) << (RND_SHIFT - 1);
    localparam wide_t SAT_MAX  = wide_t'((1 << (DW - 1)) - 1);
    localparam wide_t SAT_MIN  = wide_t'(-(1 << (DW - 1)));

    function automatic sat_t sat18(input wide_t v);
        sat_t r;
        r.ovf = (v > SAT_MAX) || (v < SAT_MIN);
        if (v > SAT_MAX)
            r.v = SAT_MAX[DW-1:0];
        else if (v < SAT_MIN)
            r.v = SAT_MIN[DW-1:0];
        else
            r.v = v[DW-1:0];
        return r;
    endfunction

endpackage

// File: rtl/fft_bfly_rnd_if.sv
// Butterfly stage bus: top-leg sample, multiplier product, control and both output legs.
interface fft_bfly_rnd_if;
    import fft_pkg::*;

    logic                 in_valid;
    sample_t              x_real;
    sample_t              x_imag;
    logic signed [PW-1:0] prod_real;
    logic signed [PW-1:0] prod_imag;
    logic                 scale_en;
    logic                 ovf_clr;
    logic                 out_valid;
    sample_t              a_real;
    sample_t              a_imag;
    sample_t              b_real;
    sample_t              b_imag;
    logic                 ovf_sticky;

    modport master (
        output in_valid, x_real, x_imag, prod_real, prod_imag, scale_en, ovf_clr,
        input  out_valid, a_real, a_imag, b_real, b_imag, ovf_sticky
    );

    modport slave (
        input  in_valid, x_real, x_imag, prod_real, prod_imag, scale_en, ovf_clr,
        output out_valid, a_real, a_imag, b_real, b_imag, ovf_sticky
    );

endinterface

// File: rtl/fft_rnd_sat.sv
// One real component: optional round-half-up right shift, then saturate to 18 bits.
module fft_rnd_sat
    import fft_pkg::*;
#(
    parameter int    IW    = PW,
    parameter int    SHIFT = 0,
    parameter wide_t HALF  = '0
) (
    input  logic signed [IW-1:0] din,
    output sample_t              dout,
    output logic                 ovf
);

    wide_t ext;
    wide_t rnd;
    sat_t  res;

    // Working width leaves headroom so the rounding add can never wrap.
    assign ext  = wide_t'(din);
    assign rnd  = (ext + HALF) >>> SHIFT;
    assign res  = sat18(rnd);
    assign dout = res.v;
    assign ovf  = res.ovf;

endmodule

// File: rtl/fft_bfly_rnd.sv
// Radix-2 DIT butterfly behind the complex multiplier: round/saturate W*y, then x +/- W*y.
module fft_bfly_rnd
    import fft_pkg::*;
#(
    parameter int DW      = fft_pkg::DW,
    parameter int PW      = fft_pkg::PW,
    parameter int MUL_LAT = 2
) (
    input  logic          clock,
    input  logic          reset_n,
    fft_bfly_rnd_if.slave bus
);

    // x / scale / valid delay line matching the multiplier latency
    logic [MUL_LAT-1:0] vld_pipe;
    logic [MUL_LAT-1:0] scl_pipe;
    cplx_t              x_pipe [MUL_LAT];

    always_ff @(posedge clock) begin
        if (!reset_n)
            vld_pipe <= '0;
        else
            vld_pipe <= (vld_pipe << 1) | MUL_LAT'(bus.in_valid);
    end

    always_ff @(posedge clock) begin
        if (bus.in_valid) begin
            x_pipe[0]   <= '{re: bus.x_real, im: bus.x_imag};
            scl_pipe[0] <= bus.scale_en;
        end
        for (int i = 1; i < MUL_LAT; i++) begin
            if (vld_pipe[i-1]) begin
                x_pipe[i]   <= x_pipe[i-1];
                scl_pipe[i] <= scl_pipe[i-1];
            end
        end
    end

    logic    vld_m;
    logic    scl_m;
    cplx_t   x_m;
    sample_t pr_re, pr_im;
    logic    ovf_pre, ovf_pim;

    assign vld_m = vld_pipe[MUL_LAT-1];
    assign scl_m = scl_pipe[MUL_LAT-1];
    assign x_m   = x_pipe[MUL_LAT-1];

    fft_rnd_sat #(.IW(PW), .SHIFT(RND_SHIFT), .HALF(RND_HALF)) u_rnd_re (
        .din(bus.prod_real), .dout(pr_re), .ovf(ovf_pre)
    );
    fft_rnd_sat #(.IW(PW), .SHIFT(RND_SHIFT), .HALF(RND_HALF)) u_rnd_im (
        .din(bus.prod_imag), .dout(pr_im), .ovf(ovf_pim)
    );

    // Stage R registers
    logic  vld_r, scl_r, ovf_r;
    cplx_t p_r, x_r;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            vld_r <= 1'b0;
            ovf_r <= 1'b0;
        end else begin
            vld_r <= vld_m;
            ovf_r <= vld_m & (ovf_pre | ovf_pim);
        end
    end

    always_ff @(posedge clock) begin
        if (vld_m) begin
            p_r   <= '{re: pr_re, im: pr_im};
            x_r   <= x_m;
            scl_r <= scl_m;
        end
    end

    // Stage B: 0 = a.re, 1 = a.im, 2 = b.re, 3 = b.im
    logic signed [DW:0] bf_v   [4];
    sample_t            bf_sat [4];
    sample_t            bf_scl [4];
    logic [3:0]         bf_ovf;

    always_comb begin
        bf_v[0] = {x_r.re[DW-1], x_r.re} + {p_r.re[DW-1], p_r.re};
        bf_v[1] = {x_r.im[DW-1], x_r.im} + {p_r.im[DW-1], p_r.im};
        bf_v[2] = {x_r.re[DW-1], x_r.re} - {p_r.re[DW-1], p_r.re};
        bf_v[3] = {x_r.im[DW-1], x_r.im} - {p_r.im[DW-1], p_r.im};
    end

    for (genvar g = 0; g < 4; g++) begin : g_bf
        fft_rnd_sat #(.IW(DW + 1), .SHIFT(0), .HALF('0)) u_sat (
            .din(bf_v[g]), .dout(bf_sat[g]), .ovf(bf_ovf[g])
        );
        // Halving a 19-bit sum with round-half-up always lands inside 18 bits.
        assign bf_scl[g] = sample_t'((bf_v[g] + (DW + 1)'(1)) >>> 1);
    end

    logic ovf_b;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            bus.out_valid <= 1'b0;
            ovf_b         <= 1'b0;
            bus.a_real    <= '0;
            bus.a_imag    <= '0;
            bus.b_real    <= '0;
            bus.b_imag    <= '0;
        end else begin
            bus.out_valid <= vld_r;
            ovf_b         <= vld_r & ~scl_r & (|bf_ovf);
            if (vld_r) begin
                bus.a_real <= scl_r ? bf_scl[0] : bf_sat[0];
                bus.a_imag <= scl_r ? bf_scl[1] : bf_sat[1];
                bus.b_real <= scl_r ? bf_scl[2] : bf_sat[2];
                bus.b_imag <= scl_r ? bf_scl[3] : bf_sat[3];
            end
        end
    end

    // Clear has priority over an event landing in the same cycle.
    always_ff @(posedge clock) begin
        if (!reset_n)
            bus.ovf_sticky <= 1'b0;
        else
            bus.ovf_sticky <= (bus.ovf_sticky | ovf_r | ovf_b) & ~bus.ovf_clr;
    end

endmodule

// File: tb/tb_fft_bfly_rnd.sv
// Directed scoreboard bench for fft_bfly_rnd: expected legs queued at issue, checked on out_valid.
module tb_fft_bfly_rnd;
    import fft_pkg::*;

    typedef logic signed [PW-1:0] prod_t;
    typedef struct {
        int due;
        int ar, ai, br, bi;
    } exp_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    fft_bfly_rnd_if bus();

    fft_bfly_rnd #(.DW(DW), .PW(PW), .MUL_LAT(2)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int    cyc = 0;
    int    total = 0;
    int    bad = 0;
    exp_t  sb[$];
    prod_t pre[int];
    prod_t pim[int];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    // Product lands MUL_LAT cycles after the matching in_valid.
    always @(posedge clock) begin
        #1;
        bus.prod_real = pre.exists(cyc) ? pre[cyc] : '0;
        bus.prod_imag = pim.exists(cyc) ? pim[cyc] : '0;
    end

    always @(negedge clock) begin
        exp_t e;
        if (bus.out_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_out: got out_valid=1 want 0 (cyc %0d)", cyc);
            end else begin
                e = sb.pop_front();
                chk("latency", cyc, e.due);
                chk("a_real", bus.a_real, e.ar);
                chk("a_imag", bus.a_imag, e.ai);
                chk("b_real", bus.b_real, e.br);
                chk("b_imag", bus.b_imag, e.bi);
            end
        end
    end

    task automatic send(input int xr, input int xi, input prod_t pr, input prod_t pi,
                        input logic scl, input logic track,
                        input int ar, input int ai, input int br, input int bi,
                        output int k);
        @(posedge clock);
        #1;
        k            = cyc;
        bus.in_valid = 1'b1;
        bus.x_real   = sample_t'(xr);
        bus.x_imag   = sample_t'(xi);
        bus.scale_en = scl;
        pre[k + 2]   = pr;
        pim[k + 2]   = pi;
        if (track) sb.push_back('{due: k + 4, ar: ar, ai: ai, br: br, bi: bi});
    endtask

    task automatic idle();
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clock);
            #1;
        end
        @(negedge clock);
    endtask

    prod_t p_sat, p_max, p_min;
    int    k;
    int    lim;

    initial begin
        p_sat = prod_t'(64'sd131071 <<< 17);
        p_max = prod_t'(64'sd34359738367);
        p_min = prod_t'(-64'sd34359738368);

        bus.in_valid = 1'b0;
        bus.x_real   = '0;
        bus.x_imag   = '0;
        bus.scale_en = 1'b0;
        bus.ovf_clr  = 1'b0;

        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_a_real", bus.a_real, 0);
        chk("rst_b_imag", bus.b_imag, 0);
        chk("rst_sticky", bus.ovf_sticky, 0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // basic, scaled, rounding points
        send(1000, -500, 300 * 131072, 0, 1'b0, 1'b1, 1300, -500, 700, -500, k);
        send(1000, -500, 300 * 131072, 0, 1'b1, 1'b1, 650, -250, 350, -250, k);
        send(0, 0, 3 * 65536, 0, 1'b0, 1'b1, 2, 0, -2, 0, k);
        send(0, 0, 65536, 0, 1'b0, 1'b1, 1, 0, -1, 0, k);
        send(0, 0, -65536, 0, 1'b0, 1'b1, 0, 0, 0, 0, k);
        idle();
        goto(k + 6);

        // butterfly saturation, unscaled: sticky one cycle after outputs
        bus.ovf_clr = 1'b1;
        send(131071, 0, p_sat, 0, 1'b0, 1'b1, 131071, 0, 0, 0, k);
        bus.ovf_clr = 1'b0;
        idle();
        goto(k + 4);
        chk("sticky_b_early", bus.ovf_sticky, 0);
        goto(k + 5);
        chk("sticky_b_set", bus.ovf_sticky, 1);

        // same input scaled never flags
        bus.ovf_clr = 1'b1;
        send(131071, 0, p_sat, 0, 1'b1, 1'b1, 131071, 0, 0, 0, k);
        bus.ovf_clr = 1'b0;
        idle();
        goto(k + 6);
        chk("sticky_scaled", bus.ovf_sticky, 0);

        // clear coinciding with a new event wins
        send(131071, 0, p_sat, 0, 1'b0, 1'b1, 131071, 0, 0, 0, k);
        idle();
        goto(k + 4);
        bus.ovf_clr = 1'b1;
        goto(k + 5);
        chk("sticky_clr_wins", bus.ovf_sticky, 0);
        bus.ovf_clr = 1'b0;
        goto(k + 6);
        chk("sticky_clr_hold", bus.ovf_sticky, 0);

        // product-rounding saturation, flagged one cycle earlier
        send(0, 0, p_max, 0, 1'b1, 1'b1, 65536, 0, -65535, 0, k);
        idle();
        goto(k + 3);
        chk("sticky_r_early", bus.ovf_sticky, 0);
        goto(k + 4);
        chk("sticky_r_set", bus.ovf_sticky, 1);
        send(0, 0, p_min, 0, 1'b0, 1'b1, -131072, 0, 131071, 0, k);
        idle();
        goto(k + 6);

        // streaming ramp
        for (int i = 0; i < 16; i++)
            send(i, -i, prod_t'(i * 131072), prod_t'(-i * 131072), 1'b0, 1'b1,
                 2 * i, -2 * i, 0, 0, k);
        idle();
        goto(k + 6);

        // reset two cycles after an in_valid discards it
        send(5, 5, 7 * 131072, 0, 1'b0, 1'b0, 0, 0, 0, 0, k);
        idle();
        goto(k + 2);
        reset_n = 1'b0;
        goto(k + 3);
        reset_n = 1'b1;
        for (int n = 3; n < 7; n++) begin
            goto(k + n);
            chk("flush_out_valid", bus.out_valid, 0);
            chk("flush_a_real", bus.a_real, 0);
            chk("flush_b_imag", bus.b_imag, 0);
            chk("flush_sticky", bus.ovf_sticky, 0);
        end

        send(1, 2, 3 * 131072, 4 * 131072, 1'b0, 1'b1, 4, 6, -2, -2, k);
        idle();

        lim = 0;
        while (sb.size() > 0 && lim < 50) begin
            @(posedge clock);
            lim++;
        end
        repeat (2) @(posedge clock);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fft_bfly_rnd.md
# fft_bfly_rnd

Radix-2 decimation-in-time butterfly stage directly downstream of the 2-clock complex multiplier in the FFT datapath. It receives the multiplier's 36-bit twiddled product W·y and the unmultiplied top-leg sample x. It rounds and saturates the product back to 18 bits, forms x+W·y and x−W·y with optional divide-by-2 scaling, and emits both legs with a valid strobe. The block also internally aligns x and valid to the multiplier's fixed 2-cycle latency.

## Interface
Parameters:
- `DW`, 18: sample width (signed, Q1.17).
- `PW`, 36: product width from the multiplier (signed, Q2.34).
- `MUL_LAT`, 2: multiplier latency in clocks; sets the x/valid alignment delay.

Ports:
- `clock`  in  1  sole clock; all state is updated on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset, sampled on `clock`.
- `in_valid`  in  1  high in the same cycle the y/W operands are presented to the multiplier.
- `x_real`, `x_imag`  in  DW  top-leg sample, valid with `in_valid`.
- `prod_real`, `prod_imag`  in  PW  multiplier outputs; taken as valid exactly `MUL_LAT` cycles after `in_valid`.
- `scale_en`  in  1  1 = divide outputs by 2 with rounding; sampled with `in_valid` and pipelined alongside the data.
- `ovf_clr`  in  1  clears `ovf_sticky`.
- `out_valid`  out  1  both output legs are valid.
- `a_real`, `a_imag`  out  DW  x + W·y.
- `b_real`, `b_imag`  out  DW  x − W·y.
- `ovf_sticky`  out  1  set by any saturation event; held until `ovf_clr` or reset.

## Operation
- **Alignment:** x, `scale_en` and `in_valid` pass through a `MUL_LAT`-deep shift register so they meet the product in stage R.
- **Stage R (round):** p = (prod + 2^16) >>> 17. This is arithmetic shift with round-half-up, giving a 19-bit intermediate. The intermediate is saturated to [−131072, 131071]. Saturation sets the overflow event.
- **Stage B (butterfly):** sum = x + p and dif = x − p, both 19-bit signed.
  - With `scale_en`=1: out = (v + 1) >>> 1. This always fits in 18 bits and never flags overflow.
  - With `scale_en`=0: out = v saturated to 18 bits. Saturation sets the overflow event.
- **Overflow:** the event from any of the 6 saturators (2 in R, 4 in B) is qualified by the valid at that stage. `ovf_sticky` <= (`ovf_sticky` | event) & ~`ovf_clr`. Clear wins over a same-cycle event.
- **Reset:** while `reset_n`=0, all valid flops, `out_valid`, every output data register and `ovf_sticky` are forced to 0. Transactions in flight during reset are discarded. No output pulse appears for them after release.
- **Throughput:** fully pipelined, one butterfly per clock, no backpressure. Back-to-back `in_valid` gives back-to-back `out_valid`.
- **Data gating:** data registers load only when their stage's valid is 1 and hold otherwise.

## Timing
- `in_valid` in cycle t.
- Product sampled at t+MUL_LAT.
- Stage R registered at t+MUL_LAT+1.
- `out_valid` and outputs registered at t+MUL_LAT+2, which is t+4 with defaults.
- `ovf_sticky` rises one cycle after the offending stage registers:
  - t+4 for a stage-R saturation;
  - t+5 for a stage-B saturation.
- `reset_n` released at cycle r: an `in_valid` accepted at r or later is processed normally.

## Structure
- Shared package `fft_pkg`:
  - `DW`/`PW` constants;
  - `sample_t` (signed [DW−1:0]) and `cplx_t` struct {re, im};
  - the rounding constant and `SAT_MAX`/`SAT_MIN`;
  - a `sat18` function.
- One sub-module: `fft_rnd_sat`. It performs the shift, round and saturate of one real component and returns the value plus an overflow bit. It is instantiated twice for stage R and reused for the butterfly saturation.

## Test plan
- **Basic butterfly:** x=(1000,−500), prod=(300·2^17, 0), `scale_en`=0 -> a=(1300,−500), b=(700,−500), `out_valid` exactly 4 cycles after `in_valid`.
- **Scaling:** same stimulus with `scale_en`=1 -> a=(650,−250), b=(350,−250).
- **Rounding points:**
  - prod_real = 3·2^16 -> p=2;
  - prod_real = 2^16 -> p=1;
  - prod_real = −2^16 -> p=0;
  - check each with x=0, `scale_en`=0, reading a_real.
- **Saturation:** x_real=131071, prod_real=131071·2^17, `scale_en`=0 -> a_real=131071, b_real=0, `ovf_sticky`=1 from the next cycle. Under the same input with `scale_en`=1 -> a_real=131071, `ovf_sticky` stays 0. Assert `ovf_clr` together with a new overflow event -> `ovf_sticky`=0.
- **Streaming:** 16 consecutive `in_valid` cycles with ramp x=k and prod=k·2^17 -> 16 consecutive `out_valid` cycles with a=2k, b=0, in order.
- **Reset mid-flight:** pull `reset_n` low for 1 cycle 2 cycles after an `in_valid` -> no `out_valid` for that transaction; all outputs 0 during and after reset until new input.
